// File: rtl/alu_arbiter_pkg.sv
// Shared ALU op-code defines, widths and types for the ALU arbiter slice.
// The optional ALU_ARB_FIXED_PRIO_EN macro is consumed by alu_arbiter and alu_arb_pick.
`ifndef ALU_HEADER_DEFINES
`define ALU_HEADER_DEFINES
`define ADD_ALU 3'd0
`define SUB_ALU 3'd1
`define AND_ALU 3'd2
`define OR_ALU  3'd3
`define XOR_ALU 3'd4
`define SLT_ALU 3'd5
`define SLL_ALU 3'd6
`define SRL_ALU 3'd7
`define ALU_DATA_W 8
`define ALU_CTRL_W 3
`endif

package alu_arbiter_pkg;

    localparam int unsigned DataW = `ALU_DATA_W;
    localparam int unsigned CtrlW = `ALU_CTRL_W;

    typedef enum logic [2:0] {
        OpAdd = `ADD_ALU,
        OpSub = `SUB_ALU,
        OpAnd = `AND_ALU,
        OpOr  = `OR_ALU,
        OpXor = `XOR_ALU,
        OpSlt = `SLT_ALU,
        OpSll = `SLL_ALU,
        OpSrl = `SRL_ALU
    } alu_op_e;

endpackage

// File: rtl/alu_arb_pick.sv
// Two-way grant picker: round-robin by default, fixed priority (requester 0)
// when ALU_ARB_FIXED_PRIO_EN is defined.
module alu_arb_pick (
    input  logic [1:0] elig,
`ifndef ALU_ARB_FIXED_PRIO_EN
    input  logic       rr_ptr,
    output logic       rr_ptr_next,
`endif
    output logic [1:0] grant
);

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        grant    = 2'b00;
        grant[0] = elig[0];
        grant[1] = elig[1] & ~elig[0];
    end
`else
    always_comb begin
        grant       = elig;
        rr_ptr_next = rr_ptr;
        if (elig == 2'b11) begin
            grant = rr_ptr ? 2'b10 : 2'b01;
        end
        // Favour the other requester after any grant; hold when idle.
        if (grant[0]) begin
            rr_ptr_next = 1'b1;
        end else if (grant[1]) begin
            rr_ptr_next = 1'b0;
        end
    end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters with one-deep registered response slots.
// ALU_ARB_FIXED_PRIO_EN selects fixed priority for requester 0 instead of round-robin.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = DataW,
    parameter int unsigned CTRL_W = CtrlW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0Valid,
    output logic              req0Ready,
    input  logic [CTRL_W-1:0] req0Ctrl,
    input  logic [DATA_W-1:0] req0A,
    input  logic [DATA_W-1:0] req0B,
    input  logic              req1Valid,
    output logic              req1Ready,
    input  logic [CTRL_W-1:0] req1Ctrl,
    input  logic [DATA_W-1:0] req1A,
    input  logic [DATA_W-1:0] req1B,
    output logic              rsp0Valid,
    input  logic              rsp0Ready,
    output logic [DATA_W-1:0] rsp0Result,
    output logic              rsp0Zero,
    output logic              rsp1Valid,
    input  logic              rsp1Ready,
    output logic [DATA_W-1:0] rsp1Result,
    output logic              rsp1Zero,
    output logic [CTRL_W-1:0] aluCtrl,
    output logic [DATA_W-1:0] operandA,
    output logic [DATA_W-1:0] operandB,
    input  logic [DATA_W-1:0] aluResult,
    input  logic              aluZero
);

    logic [1:0]        elig;
    logic [1:0]        grant;
    logic [1:0]        rsp_ready;
    logic [1:0]        rsp_valid_q;
    logic [1:0]        rsp_zero_q;
    logic [DATA_W-1:0] rsp_result_q [2];

    assign rsp_ready = {rsp1Ready, rsp0Ready};

    // Reset also masks eligibility so nothing is granted while rst_n is low.
    assign elig[0] = rst_n & req0Valid & (~rsp_valid_q[0] | rsp0Ready);
    assign elig[1] = rst_n & req1Valid & (~rsp_valid_q[1] | rsp1Ready);

`ifdef ALU_ARB_FIXED_PRIO_EN
    alu_arb_pick u_pick (
        .elig  (elig),
        .grant (grant)
    );
`else
    logic rr_ptr_q;
    logic rr_ptr_d;

    alu_arb_pick u_pick (
        .elig        (elig),
        .rr_ptr      (rr_ptr_q),
        .rr_ptr_next (rr_ptr_d),
        .grant       (grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    assign req0Ready = grant[0];
    assign req1Ready = grant[1];

    always_comb begin
        aluCtrl  = CTRL_W'(OpAdd);
        operandA = '0;
        operandB = '0;
        if (grant[0]) begin
            aluCtrl  = req0Ctrl;
            operandA = req0A;
            operandB = req0B;
        end else if (grant[1]) begin
            aluCtrl  = req1Ctrl;
            operandA = req1A;
            operandB = req1B;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= '0;
            rsp_zero_q  <= '0;
            for (int i = 0; i < 2; i++) begin
                rsp_result_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (grant[i]) begin
                    rsp_valid_q[i]  <= 1'b1;
                    rsp_result_q[i] <= aluResult;
                    rsp_zero_q[i]   <= aluZero;
                end else if (rsp_ready[i]) begin
                    rsp_valid_q[i] <= 1'b0;
                end
            end
        end
    end

    assign rsp0Valid  = rsp_valid_q[0];
    assign rsp1Valid  = rsp_valid_q[1];
    assign rsp0Result = rsp_result_q[0];
    assign rsp1Result = rsp_result_q[1];
    assign rsp0Zero   = rsp_zero_q[0];
    assign rsp1Zero   = rsp_zero_q[1];

endmodule
